// File: rtl/a2_iomem_initiator_if.sv
// Single-outstanding valid/ready request bus from the Apple II bridge to a 32-bit iomem slave.
interface a2_iomem_initiator_if;
   logic        valid;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport master (output valid, wstrb, addr, wdata, input rdata, ready);
   modport slave  (input valid, wstrb, addr, wdata, output rdata, ready);
endinterface

// File: rtl/a2_iomem_initiator.sv
// Apple II slot-window register bridge that issues one iomem request per CMD; readback is one cycle late.
// Waits on iomem ready forever unless A2_IOMEM_TIMEOUT_EN compiles in the TIMEOUT_CYCLES wait limit.
module a2_iomem_initiator #(
   parameter int SLOT           = 7,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [15:0]          a2_addr,
   input  logic [7:0]           a2_data,
   input  logic                 a2_rw_n,
   input  logic                 a2_data_in_strobe,
   output logic [7:0]           a2_rd_data_o,
   output logic                 a2_rd_sel_o,
   a2_iomem_initiator_if.master iomem
);
   localparam logic [11:0] WIN = 12'(12'hC08 + SLOT);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t      state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [3:0]  wstrb_q;
   logic        rd_q;
   logic        done_q;
   logic        tmo_q;
   logic        in_win;
   logic        reg_wr;
   logic        busy;
   logic [7:0]  status;
   logic [7:0]  rd_mux;

`ifdef A2_IOMEM_TIMEOUT_EN
   localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
   logic [CW-1:0] wait_cnt;
`endif

   assign in_win = (a2_addr[15:4] == WIN);
   assign reg_wr = a2_data_in_strobe && !a2_rw_n && in_win;
   assign busy   = (state == ACTIVE);
   assign status = {5'd0, done_q, tmo_q, busy};

   always_comb begin
      rd_mux = 8'h00;
      case (a2_addr[3:0])
         4'h0:    rd_mux = addr_q[7:0];
         4'h1:    rd_mux = addr_q[15:8];
         4'h2:    rd_mux = addr_q[23:16];
         4'h3:    rd_mux = addr_q[31:24];
         4'h4:    rd_mux = wdata_q[7:0];
         4'h5:    rd_mux = wdata_q[15:8];
         4'h6:    rd_mux = wdata_q[23:16];
         4'h7:    rd_mux = wdata_q[31:24];
         4'h8:    rd_mux = {4'h0, wstrb_q};
         4'hA:    rd_mux = status;
         4'hC:    rd_mux = rdata_q[7:0];
         4'hD:    rd_mux = rdata_q[15:8];
         4'hE:    rd_mux = rdata_q[23:16];
         4'hF:    rd_mux = rdata_q[31:24];
         default: rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         iomem.valid  <= 1'b0;
         iomem.wstrb  <= 4'h0;
         iomem.addr   <= 32'h0;
         iomem.wdata  <= 32'h0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         rdata_q      <= 32'h0;
         wstrb_q      <= 4'h0;
         rd_q         <= 1'b0;
         done_q       <= 1'b0;
         tmo_q        <= 1'b0;
         a2_rd_data_o <= 8'h00;
         a2_rd_sel_o  <= 1'b0;
`ifdef A2_IOMEM_TIMEOUT_EN
         wait_cnt     <= '0;
`endif
      end else begin
         a2_rd_data_o <= rd_mux;
         a2_rd_sel_o  <= in_win && a2_rw_n;

         // Request registers are frozen while a request is outstanding.
         if (reg_wr && !busy) begin
            case (a2_addr[3:0])
               4'h0:    addr_q[7:0]    <= a2_data;
               4'h1:    addr_q[15:8]   <= a2_data;
               4'h2:    addr_q[23:16]  <= a2_data;
               4'h3:    addr_q[31:24]  <= a2_data;
               4'h4:    wdata_q[7:0]   <= a2_data;
               4'h5:    wdata_q[15:8]  <= a2_data;
               4'h6:    wdata_q[23:16] <= a2_data;
               4'h7:    wdata_q[31:24] <= a2_data;
               4'h8:    wstrb_q        <= a2_data[3:0];
               default: ;
            endcase
         end

         case (state)
            IDLE: begin
               if (reg_wr && a2_addr[3:0] == 4'h9) begin
                  case (a2_data)
                     8'h01, 8'h02: begin
                        state       <= ACTIVE;
                        done_q      <= 1'b0;
                        tmo_q       <= 1'b0;
                        rd_q        <= (a2_data == 8'h02);
                        iomem.addr  <= addr_q;
                        iomem.wdata <= wdata_q;
                        iomem.wstrb <= (a2_data == 8'h01) ? wstrb_q : 4'h0;
`ifdef A2_IOMEM_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                     end
                     8'h00: begin
                        done_q <= 1'b0;
                        tmo_q  <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            ACTIVE: begin
               // The launch edge only records the request; valid follows one edge later.
               if (!iomem.valid) begin
                  iomem.valid <= 1'b1;
               end else if (iomem.ready) begin
                  iomem.valid <= 1'b0;
                  done_q      <= 1'b1;
                  state       <= IDLE;
                  if (rd_q) rdata_q <= iomem.rdata;
               end
`ifdef A2_IOMEM_TIMEOUT_EN
               else if (wait_cnt == CNT_LAST) begin
                  iomem.valid <= 1'b0;
                  tmo_q       <= 1'b1;
                  state       <= IDLE;
                  wait_cnt    <= CNT_MAX;
               end else begin
                  wait_cnt    <= wait_cnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_a2_iomem_initiator.sv
// Bench for a2_iomem_initiator: vector table, directed corner sequences and random traffic vs a byte-level model.
module tb_a2_iomem_initiator;
   localparam int          TMO = 255;
   localparam logic [11:0] WIN = 12'hC0F;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] a2_addr;
   logic [7:0]  a2_data;
   logic        a2_rw_n;
   logic        a2_data_in_strobe;
   logic [7:0]  a2_rd_data_o;
   logic        a2_rd_sel_o;

   a2_iomem_initiator_if iomem();

   a2_iomem_initiator #(.SLOT(7), .TIMEOUT_CYCLES(TMO)) dut (
      .clk               (clk),
      .reset             (reset),
      .a2_addr           (a2_addr),
      .a2_data           (a2_data),
      .a2_rw_n           (a2_rw_n),
      .a2_data_in_strobe (a2_data_in_strobe),
      .a2_rd_data_o      (a2_rd_data_o),
      .a2_rd_sel_o       (a2_rd_sel_o),
      .iomem             (iomem)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: register file as a byte image, transaction as "cycles since launch".
   logic [7:0]  m_img [16];
   int          m_phase;     // -1 idle, 0 launched, k>=1 valid has been high k cycles
   bit          m_rd, m_done, m_tmo;
   logic [31:0] m_sh_addr, m_sh_wdata;
   logic [3:0]  m_sh_wstrb;
   logic [7:0]  m_rd_data;
   bit          m_rd_sel;

   // Slave responder and pulse statistics
   int          s_delay;     // 0 = never respond
   int          s_cnt;
   logic [31:0] s_rdata;
   int          v_run, last_pulse, n_pulses;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_byte(input logic [3:0] off);
      if (off <= 4'h8 || off >= 4'hC) return m_img[off];
      if (off == 4'hA) return {5'd0, m_done, m_tmo, (m_phase >= 0)};
      return 8'h00;
   endfunction

   task automatic model_edge();
      logic [3:0] off;
      bit wr, busy;
      if (reset) begin
         foreach (m_img[i]) m_img[i] = 8'h00;
         m_phase = -1; m_rd = 0; m_done = 0; m_tmo = 0;
         m_sh_addr = 0; m_sh_wdata = 0; m_sh_wstrb = 0;
         m_rd_data = 0; m_rd_sel = 0;
         return;
      end
      off       = a2_addr[3:0];
      busy      = (m_phase >= 0);
      m_rd_data = m_byte(off);
      m_rd_sel  = (a2_addr[15:4] == WIN) && a2_rw_n;
      wr        = a2_data_in_strobe && !a2_rw_n && (a2_addr[15:4] == WIN);
      if (m_phase >= 1) begin
         if (iomem.ready) begin
            m_done = 1;
            if (m_rd) {m_img[15], m_img[14], m_img[13], m_img[12]} = iomem.rdata;
            m_phase = -1;
`ifdef A2_IOMEM_TIMEOUT_EN
         end else if (m_phase == TMO) begin
            m_tmo = 1;
            m_phase = -1;
`endif
         end else begin
            m_phase++;
         end
      end else if (m_phase == 0) begin
         m_phase = 1;
      end
      if (wr && !busy) begin
         if (off <= 4'h7) m_img[off] = a2_data;
         else if (off == 4'h8) m_img[8] = {4'h0, a2_data[3:0]};
         else if (off == 4'h9) begin
            if (a2_data == 8'h01 || a2_data == 8'h02) begin
               m_phase    = 0;
               m_rd       = (a2_data == 8'h02);
               m_done     = 0;
               m_tmo      = 0;
               m_sh_addr  = {m_img[3], m_img[2], m_img[1], m_img[0]};
               m_sh_wdata = {m_img[7], m_img[6], m_img[5], m_img[4]};
               m_sh_wstrb = m_rd ? 4'h0 : m_img[8][3:0];
            end else if (a2_data == 8'h00) begin
               m_done = 0;
               m_tmo  = 0;
            end
         end
      end
   endtask

   // One clock: sample after the edge, compare against the model, then update the slave.
   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      check("valid",   32'(iomem.valid),  32'(m_phase >= 1));
      check("addr",    iomem.addr,        m_sh_addr);
      check("wdata",   iomem.wdata,       m_sh_wdata);
      check("wstrb",   32'(iomem.wstrb),  32'(m_sh_wstrb));
      check("rd_data", 32'(a2_rd_data_o), 32'(m_rd_data));
      check("rd_sel",  32'(a2_rd_sel_o),  32'(m_rd_sel));
      if (iomem.valid) begin
         s_cnt++;
         iomem.ready = (s_cnt == s_delay);
         v_run++;
      end else begin
         s_cnt = 0;
         iomem.ready = 1'b0;
         if (v_run > 0) begin
            last_pulse = v_run;
            n_pulses++;
            v_run = 0;
         end
      end
      iomem.rdata = iomem.ready ? s_rdata : $urandom();
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
      a2_addr = a; a2_data = d; a2_rw_n = 1'b0; a2_data_in_strobe = 1'b1;
      step();
      a2_data_in_strobe = 1'b0; a2_rw_n = 1'b1;
   endtask

   task automatic bus_rd(input logic [3:0] off, output logic [7:0] d);
      a2_addr = {WIN, off}; a2_rw_n = 1'b1; a2_data_in_strobe = 1'b0;
      step();
      d = a2_rd_data_o;
   endtask

   // Run until the current/next valid pulse ends, checking the request fields while valid is high.
   task automatic wait_pulse(input string name, input int budget,
                             input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] es);
      int p0 = n_pulses;
      int k  = 0;
      while (n_pulses == p0 && k < budget) begin
         step();
         k++;
         if (iomem.valid) begin
            check({name, "_addr"},  iomem.addr,       ea);
            check({name, "_wdata"}, iomem.wdata,      ew);
            check({name, "_wstrb"}, 32'(iomem.wstrb), 32'(es));
         end
      end
      check({name, "_completed"}, 32'(n_pulses - p0), 32'd1);
   endtask

   typedef struct {
      logic [15:0] waddr;
      logic [7:0]  wdat;
      logic [3:0]  roff;
      logic [7:0]  exp;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] rd;
   int         p0, r, hi_cnt;
   logic [3:0] off;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: run did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; a2_addr = 16'h0; a2_data = 8'h0; a2_rw_n = 1'b1; a2_data_in_strobe = 1'b0;
      iomem.ready = 1'b0; iomem.rdata = 32'h0;
      s_delay = 1; s_cnt = 0; s_rdata = 32'h0; v_run = 0; last_pulse = 0; n_pulses = 0;
      step(); step();
      check("rst_valid",   32'(iomem.valid),  32'd0);
      check("rst_addr",    iomem.addr,        32'd0);
      check("rst_wdata",   iomem.wdata,       32'd0);
      check("rst_wstrb",   32'(iomem.wstrb),  32'd0);
      check("rst_rd_data", 32'(a2_rd_data_o), 32'd0);
      check("rst_rd_sel",  32'(a2_rd_sel_o),  32'd0);
      reset = 1'b0;
      bus_rd(4'hA, rd);
      check("rst_status", 32'(rd), 32'h00);

      // Register map, decode, read-only and no-carry behaviour from a clean reset.
      vecs.push_back('{16'hC0F0, 8'h12, 4'h0, 8'h12});
      vecs.push_back('{16'hC0E0, 8'h34, 4'h0, 8'h12});
      vecs.push_back('{16'hC0F1, 8'hFF, 4'h1, 8'hFF});
      vecs.push_back('{16'hC0F0, 8'h00, 4'h1, 8'hFF});
      vecs.push_back('{16'hC0F0, 8'h01, 4'h0, 8'h01});
      vecs.push_back('{16'hC0F7, 8'hA5, 4'h7, 8'hA5});
      vecs.push_back('{16'hC0F8, 8'hFF, 4'h8, 8'h0F});
      vecs.push_back('{16'hC0FA, 8'hFF, 4'hA, 8'h00});
      vecs.push_back('{16'hC0FB, 8'h77, 4'hB, 8'h00});
      vecs.push_back('{16'hC0FC, 8'h99, 4'hC, 8'h00});
      vecs.push_back('{16'hC1F0, 8'hAA, 4'h0, 8'h01});
      vecs.push_back('{16'hC070, 8'h55, 4'h0, 8'h01});
      vecs.push_back('{16'hC0F9, 8'h07, 4'h9, 8'h00});
      vecs.push_back('{16'hC0F9, 8'h07, 4'hA, 8'h00});
      foreach (vecs[i]) begin
         bus_wr(vecs[i].waddr, vecs[i].wdat);
         bus_rd(vecs[i].roff, rd);
         check($sformatf("vec%0d", i), 32'(rd), 32'(vecs[i].exp));
      end

      // Write path, slave answers on the third valid cycle.
      bus_wr(16'hC0F0, 8'h44); bus_wr(16'hC0F1, 8'h00); bus_wr(16'hC0F2, 8'h00); bus_wr(16'hC0F3, 8'h02);
      bus_wr(16'hC0F4, 8'hA5); bus_wr(16'hC0F5, 8'h00); bus_wr(16'hC0F6, 8'h00); bus_wr(16'hC0F7, 8'h00);
      bus_wr(16'hC0F8, 8'h01);
      s_delay = 3;
      bus_wr(16'hC0F9, 8'h01);
      check("wr_valid_delayed", 32'(iomem.valid), 32'd0);
      wait_pulse("wr", 20, 32'h02000044, 32'h000000A5, 4'h1);
      check("wr_pulse_len", 32'(last_pulse), 32'd3);
      bus_rd(4'hA, rd);
      check("wr_status", 32'(rd), 32'h04);

      // Read path, one-cycle slave.
      s_delay = 1; s_rdata = 32'hDEADBEEF;
      bus_wr(16'hC0F9, 8'h02);
      wait_pulse("rd", 20, 32'h02000044, 32'h000000A5, 4'h0);
      check("rd_pulse_len", 32'(last_pulse), 32'd1);
      bus_rd(4'hC, rd); check("rd_C", 32'(rd), 32'hEF);
      bus_rd(4'hD, rd); check("rd_D", 32'(rd), 32'hBE);
      bus_rd(4'hE, rd); check("rd_E", 32'(rd), 32'hAD);
      bus_rd(4'hF, rd); check("rd_F", 32'(rd), 32'hDE);
      bus_rd(4'hA, rd); check("rd_status", 32'(rd), 32'h04);

      // Busy protection: ADDR0 and a second CMD land while the request is outstanding.
      p0 = n_pulses; s_delay = 4;
      bus_wr(16'hC0F9, 8'h01);
      bus_wr(16'hC0F0, 8'h55);
      bus_wr(16'hC0F9, 8'h01);
      check("busy_addr", iomem.addr, 32'h02000044);
      wait_pulse("busy", 20, 32'h02000044, 32'h000000A5, 4'h1);
      repeat (10) step();
      check("busy_one_pulse", 32'(n_pulses - p0), 32'd1);
      bus_rd(4'h0, rd); check("busy_addr0", 32'(rd), 32'h44);

      // Slave never responds.
      s_delay = 0;
      bus_wr(16'hC0F9, 8'h02);
`ifdef A2_IOMEM_TIMEOUT_EN
      wait_pulse("tmo", 300, 32'h02000044, 32'h000000A5, 4'h0);
      check("tmo_pulse_len", 32'(last_pulse), 32'd255);
      bus_rd(4'hA, rd); check("tmo_status", 32'(rd), 32'h02);
      bus_rd(4'hC, rd); check("tmo_rdata_C", 32'(rd), 32'hEF);
      bus_rd(4'hF, rd); check("tmo_rdata_F", 32'(rd), 32'hDE);
`else
      hi_cnt = 0;
      step();
      repeat (1000) begin
         step();
         if (iomem.valid) hi_cnt++;
      end
      check("notmo_valid_held", 32'(hi_cnt), 32'd1000);
      bus_rd(4'hA, rd); check("notmo_status", 32'(rd), 32'h01);
      reset = 1'b1; step(); reset = 1'b0;
`endif

      // Reset while valid is high, then a clean read.
      s_delay = 0;
      bus_wr(16'hC0F9, 8'h02);
      step(); step();
      check("mid_valid_before", 32'(iomem.valid), 32'd1);
      reset = 1'b1; step(); reset = 1'b0;
      check("mid_valid_after", 32'(iomem.valid), 32'd0);
      bus_rd(4'hA, rd); check("mid_status", 32'(rd), 32'h00);
      s_delay = 2; s_rdata = 32'h12345678;
      bus_wr(16'hC0F9, 8'h02);
      wait_pulse("post_rst", 20, 32'h0, 32'h0, 4'h0);
      bus_rd(4'hA, rd); check("post_rst_status", 32'(rd), 32'h04);
      bus_rd(4'hC, rd); check("post_rst_C", 32'(rd), 32'h78);
      bus_rd(4'hF, rd); check("post_rst_F", 32'(rd), 32'h12);

      // Random bus traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         r = $urandom_range(0, 99);
         if (!iomem.valid) begin
            s_delay = $urandom_range(1, 6);
            s_rdata = $urandom();
         end
         reset = ($urandom_range(0, 399) == 0);
         a2_data = 8'($urandom());
         a2_rw_n = 1'b1;
         a2_data_in_strobe = 1'b0;
         if (r < 30) begin
            off = ($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom());
            a2_addr = {WIN, off};
            a2_rw_n = 1'b0;
            a2_data_in_strobe = 1'b1;
            if (off == 4'h9 && $urandom_range(0, 3) != 0) a2_data = 8'($urandom_range(0, 2));
         end else if (r < 40) begin
            a2_addr = 16'($urandom());
            if (a2_addr[15:4] == WIN) a2_addr[8] = ~a2_addr[8];
            a2_rw_n = 1'b0;
            a2_data_in_strobe = 1'b1;
         end else if (r < 80) begin
            a2_addr = {WIN, 4'($urandom())};
            a2_data_in_strobe = ($urandom_range(0, 1) == 1);
         end else begin
            a2_addr = 16'($urandom());
         end
         step();
      end
      reset = 1'b0; a2_data_in_strobe = 1'b0; a2_rw_n = 1'b1;
      repeat (10) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
